// File: rtl/cache_tag_controller.sv
// Cache tag controller: sequences tag lookup, dirty-victim writeback, line fill and
// tag/state update for single CPU requests, with saturating hit/miss counters.
module cache_tag_controller #(
    parameter int TAG_WIDTH     = 8,
    parameter int INDEX_WIDTH   = 4,
    parameter int OFFSET_WIDTH  = 4,
    parameter int ADDRESS_WIDTH = TAG_WIDTH + INDEX_WIDTH + OFFSET_WIDTH
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     cpuRead,
    input  logic                     cpuWrite,
    input  logic [ADDRESS_WIDTH-1:0] cpuAddress,
    output logic                     cpuDone,
    output logic [INDEX_WIDTH-1:0]   index,
    output logic [TAG_WIDTH-1:0]     tagIn,
    output logic [1:0]               stateIn,
    output logic                     writeTag,
    output logic                     writeState,
    input  logic [TAG_WIDTH-1:0]     tagOut,
    input  logic [1:0]               stateOut,
    input  logic                     hit,
    output logic                     memReadRequest,
    output logic                     memWriteRequest,
    output logic [ADDRESS_WIDTH-1:0] memAddress,
    input  logic                     memAck,
    output logic [15:0]              hitCount,
    output logic [15:0]              missCount
);

    localparam logic [1:0] ST_INVALID = 2'b00;
    localparam logic [1:0] ST_VALID   = 2'b01;
    localparam logic [1:0] ST_DIRTY   = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_WRITEBACK,
        S_FILL,
        S_UPDATE,
        S_DONE
    } state_t;

    state_t                   r_state;
    logic [ADDRESS_WIDTH-1:0] r_addr;
    logic [ADDRESS_WIDTH-1:0] r_victim;
    logic                     r_write;
    logic [15:0]              r_hit_count;
    logic [15:0]              r_miss_count;

    logic [TAG_WIDTH-1:0]     w_tag;
    logic [INDEX_WIDTH-1:0]   w_index;
    logic [ADDRESS_WIDTH-1:0] w_fill_addr;
    logic                     w_lookup_hit;
    logic                     w_lookup_miss;
    logic [15:0]              w_hit_next;
    logic [15:0]              w_miss_next;
    logic                     w_unused_offset;

    assign w_tag           = r_addr[ADDRESS_WIDTH-1 -: TAG_WIDTH];
    assign w_index         = r_addr[OFFSET_WIDTH +: INDEX_WIDTH];
    assign w_fill_addr     = {w_tag, w_index, {OFFSET_WIDTH{1'b0}}};
    assign w_unused_offset = ^r_addr[OFFSET_WIDTH-1:0];
    assign w_lookup_hit    = (r_state == S_LOOKUP) && hit;
    assign w_lookup_miss   = (r_state == S_LOOKUP) && !hit;

    // Counters load their next value every cycle and stop at all-ones.
    assign w_hit_next  = (w_lookup_hit  && (r_hit_count  != 16'hFFFF)) ? r_hit_count  + 16'd1 : r_hit_count;
    assign w_miss_next = (w_lookup_miss && (r_miss_count != 16'hFFFF)) ? r_miss_count + 16'd1 : r_miss_count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_addr   <= '0;
            r_victim <= '0;
            r_write  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cpuRead || cpuWrite) begin
                        r_addr  <= cpuAddress;
                        r_write <= cpuWrite;
                        r_state <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (hit) begin
                        r_state <= S_DONE;
                    end else if (stateOut == ST_DIRTY) begin
                        r_victim <= {tagOut, w_index, {OFFSET_WIDTH{1'b0}}};
                        r_state  <= S_WRITEBACK;
                    end else begin
                        r_state <= S_FILL;
                    end
                end
                S_WRITEBACK: if (memAck) r_state <= S_FILL;
                S_FILL:      if (memAck) r_state <= S_UPDATE;
                S_UPDATE:    r_state <= S_DONE;
                S_DONE:      r_state <= S_IDLE;
                default:     r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            r_hit_count  <= w_hit_next;
            r_miss_count <= w_miss_next;
        end
    end

    // Strobes decode straight from the state register so an async reset clears them at once;
    // the write-hit state update must land inside the LOOKUP cycle itself.
    // NOTE: every output gets a default first so no path through the block infers a latch.
    always_comb begin
        cpuDone         = 1'b0;
        writeTag        = 1'b0;
        writeState      = 1'b0;
        stateIn         = ST_INVALID;
        memReadRequest  = 1'b0;
        memWriteRequest = 1'b0;
        memAddress      = '0;
        case (r_state)
            S_LOOKUP: begin
                if (hit && r_write) begin
                    writeState = 1'b1;
                    stateIn    = ST_DIRTY;
                end
            end
            S_WRITEBACK: begin
                memWriteRequest = 1'b1;
                memAddress      = r_victim;
            end
            S_FILL: begin
                memReadRequest = 1'b1;
                memAddress     = w_fill_addr;
            end
            S_UPDATE: begin
                writeTag   = 1'b1;
                writeState = 1'b1;
                stateIn    = r_write ? ST_DIRTY : ST_VALID;
            end
            S_DONE:  cpuDone = 1'b1;
            default: ;
        endcase
    end

    assign index     = w_index;
    assign tagIn     = w_tag;
    assign hitCount  = r_hit_count;
    assign missCount = r_miss_count;

endmodule

// File: tb/tb_cache_tag_controller.sv
// Bench for cache_tag_controller: behavioural tag unit and memory responder,
// expected tag-unit/memory/cpu events queued per request and compared as they occur.
module tb_cache_tag_controller;

    localparam int TW = 8;
    localparam int IW = 4;
    localparam int OW = 4;
    localparam int AW = TW + IW + OW;

    localparam logic [1:0] ST_INVALID = 2'b00;
    localparam logic [1:0] ST_VALID   = 2'b01;
    localparam logic [1:0] ST_DIRTY   = 2'b10;

    logic          clock = 1'b0;
    logic          reset;
    logic          cpuRead, cpuWrite;
    logic [AW-1:0] cpuAddress;
    logic          cpuDone;
    logic [IW-1:0] index;
    logic [TW-1:0] tagIn;
    logic [1:0]    stateIn;
    logic          writeTag, writeState;
    logic [TW-1:0] tagOut;
    logic [1:0]    stateOut;
    logic          hit;
    logic          memReadRequest, memWriteRequest;
    logic [AW-1:0] memAddress;
    logic          memAck;
    logic [15:0]   hitCount, missCount;

    always #5 clock = ~clock;

    cache_tag_controller #(
        .TAG_WIDTH(TW), .INDEX_WIDTH(IW), .OFFSET_WIDTH(OW), .ADDRESS_WIDTH(AW)
    ) dut (
        .clock(clock), .reset(reset),
        .cpuRead(cpuRead), .cpuWrite(cpuWrite), .cpuAddress(cpuAddress), .cpuDone(cpuDone),
        .index(index), .tagIn(tagIn), .stateIn(stateIn),
        .writeTag(writeTag), .writeState(writeState),
        .tagOut(tagOut), .stateOut(stateOut), .hit(hit),
        .memReadRequest(memReadRequest), .memWriteRequest(memWriteRequest),
        .memAddress(memAddress), .memAck(memAck),
        .hitCount(hitCount), .missCount(missCount)
    );

    typedef enum logic [1:0] {EV_MEMWR, EV_MEMRD, EV_TAGWR, EV_DONE} ev_kind_t;
    typedef struct packed {
        ev_kind_t      kind;
        logic [AW-1:0] addr;
        logic          wt;
        logic          ws;
        logic [TW-1:0] tag;
        logic [1:0]    st;
        logic [IW-1:0] idx;
    } ev_t;

    ev_t exp_q[$];
    int  total = 0;
    int  bad   = 0;

    task automatic check(input string name, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", name, observed, expected);
        end
    endtask

    function automatic ev_t mk(input ev_kind_t k, input logic [AW-1:0] a, input logic wt,
                               input logic ws, input logic [TW-1:0] t, input logic [1:0] s,
                               input logic [IW-1:0] i);
        ev_t e;
        e.kind = k; e.addr = a; e.wt = wt; e.ws = ws; e.tag = t; e.st = s; e.idx = i;
        return e;
    endfunction

    task automatic observe(input string name, input ev_t got);
        ev_t e;
        check({name, "_expected"}, 64'(exp_q.size() > 0), 64'(1));
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check(name, 64'(got), 64'(e));
        end
    endtask

    // Behavioural tag unit: combinational read, writes at the clock edge.
    logic [TW-1:0] tag_mem [16];
    logic [1:0]    st_mem  [16];
    logic          pl_en = 1'b0;
    logic [IW-1:0] pl_idx;
    logic [TW-1:0] pl_tag;
    logic [1:0]    pl_st;

    always @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) begin
                tag_mem[i] <= '0;
                st_mem[i]  <= ST_INVALID;
            end
        end else if (pl_en) begin
            tag_mem[pl_idx] <= pl_tag;
            st_mem[pl_idx]  <= pl_st;
        end else begin
            if (writeTag)   tag_mem[index] <= tagIn;
            if (writeState) st_mem[index]  <= stateIn;
        end
    end

    assign tagOut   = tag_mem[index];
    assign stateOut = st_mem[index];
    assign hit      = (tag_mem[index] == tagIn) && (st_mem[index] != ST_INVALID);

    // Memory responder plus event monitor, both on the falling edge.
    int   ack_delay = 0;
    int   wait_cnt  = 0;
    logic ack_en    = 1'b1;
    logic force_ack = 1'b0;

    always @(negedge clock) begin
        if (ack_en && (memReadRequest || memWriteRequest)) begin
            memAck   = (wait_cnt == ack_delay);
            wait_cnt = memAck ? 0 : wait_cnt + 1;
        end else begin
            memAck   = force_ack;
            wait_cnt = 0;
        end
        if (reset) begin
            if (memReadRequest || memWriteRequest)
                check("mem_req_exclusive", 64'(memReadRequest & memWriteRequest), 64'(0));
            if (memAck && memWriteRequest)
                observe("memwr", mk(EV_MEMWR, memAddress, 1'b0, 1'b0, '0, '0, '0));
            if (memAck && memReadRequest)
                observe("memrd", mk(EV_MEMRD, memAddress, 1'b0, 1'b0, '0, '0, '0));
            if (writeTag || writeState)
                observe("tagwr", mk(EV_TAGWR, '0, writeTag, writeState, tagIn, stateIn, index));
            if (cpuDone)
                observe("done", mk(EV_DONE, '0, 1'b0, 1'b0, '0, '0, '0));
        end
    end

    task automatic preload(input logic [IW-1:0] i, input logic [TW-1:0] t, input logic [1:0] s);
        @(negedge clock);
        pl_en = 1'b1; pl_idx = i; pl_tag = t; pl_st = s;
        @(negedge clock);
        pl_en = 1'b0;
    endtask

    task automatic do_req(input string name, input logic rd, input logic wr,
                          input logic [AW-1:0] addr, input int exp_lat);
        int   lat;
        logic done;
        @(negedge clock);
        cpuRead = rd; cpuWrite = wr; cpuAddress = addr;
        lat = 0; done = 1'b0;
        while (!done && lat < 40) begin
            @(negedge clock);
            lat++;
            done = cpuDone;
        end
        check({name, "_done"}, 64'(done), 64'(1));
        check({name, "_latency"}, 64'(lat), 64'(exp_lat));
        cpuRead = 1'b0; cpuWrite = 1'b0;
        @(negedge clock);
        check({name, "_drained"}, 64'(exp_q.size()), 64'(0));
        exp_q.delete();
    endtask

    logic [15:0] exp_hit  = '0;
    logic [15:0] exp_miss = '0;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; cpuRead = 1'b0; cpuWrite = 1'b0; cpuAddress = '0;
        repeat (3) @(negedge clock);
        check("rst_cpuDone",    64'(cpuDone), 64'(0));
        check("rst_memRd",      64'(memReadRequest), 64'(0));
        check("rst_memWr",      64'(memWriteRequest), 64'(0));
        check("rst_writeTag",   64'(writeTag), 64'(0));
        check("rst_writeState", 64'(writeState), 64'(0));
        check("rst_hitCount",   64'(hitCount), 64'(0));
        check("rst_missCount",  64'(missCount), 64'(0));
        reset = 1'b1;

        // Read hit
        preload(4'd3, 8'hA5, ST_VALID);
        exp_q.push_back(mk(EV_DONE, '0, 1'b0, 1'b0, '0, '0, '0));
        do_req("read_hit", 1'b1, 1'b0, 16'hA530, 2);
        exp_hit = sat_inc(exp_hit);
        check("read_hit_hitCount", 64'(hitCount), 64'(exp_hit));

        // Clean read miss, ack in the fifth FILL cycle
        preload(4'd3, 8'h00, ST_INVALID);
        ack_delay = 4;
        exp_q.push_back(mk(EV_MEMRD, 16'hA530, 1'b0, 1'b0, '0, '0, '0));
        exp_q.push_back(mk(EV_TAGWR, '0, 1'b1, 1'b1, 8'hA5, ST_VALID, 4'd3));
        exp_q.push_back(mk(EV_DONE, '0, 1'b0, 1'b0, '0, '0, '0));
        do_req("clean_miss", 1'b1, 1'b0, 16'hA530, 4 + 4);
        exp_miss = sat_inc(exp_miss);
        check("clean_miss_missCount", 64'(missCount), 64'(exp_miss));

        // Write hit with read and write both asserted: only the state is rewritten
        exp_q.push_back(mk(EV_TAGWR, '0, 1'b0, 1'b1, 8'hA5, ST_DIRTY, 4'd3));
        exp_q.push_back(mk(EV_DONE, '0, 1'b0, 1'b0, '0, '0, '0));
        do_req("write_hit", 1'b1, 1'b1, 16'hA53C, 2);
        exp_hit = sat_inc(exp_hit);
        check("write_hit_hitCount", 64'(hitCount), 64'(exp_hit));
        check("write_hit_state", 64'(st_mem[3]), 64'(ST_DIRTY));

        // Dirty write miss: writeback of the victim, then fill
        preload(4'd3, 8'h11, ST_DIRTY);
        ack_delay = 1;
        exp_q.push_back(mk(EV_MEMWR, 16'h1130, 1'b0, 1'b0, '0, '0, '0));
        exp_q.push_back(mk(EV_MEMRD, 16'hA530, 1'b0, 1'b0, '0, '0, '0));
        exp_q.push_back(mk(EV_TAGWR, '0, 1'b1, 1'b1, 8'hA5, ST_DIRTY, 4'd3));
        exp_q.push_back(mk(EV_DONE, '0, 1'b0, 1'b0, '0, '0, '0));
        do_req("dirty_miss", 1'b0, 1'b1, 16'hA534, 2 * 1 + 5);
        exp_miss = sat_inc(exp_miss);
        check("dirty_miss_missCount", 64'(missCount), 64'(exp_miss));

        // Zero-wait ack on a clean miss at another index
        preload(4'd5, 8'h00, ST_INVALID);
        ack_delay = 0;
        exp_q.push_back(mk(EV_MEMRD, 16'h3C50, 1'b0, 1'b0, '0, '0, '0));
        exp_q.push_back(mk(EV_TAGWR, '0, 1'b1, 1'b1, 8'h3C, ST_VALID, 4'd5));
        exp_q.push_back(mk(EV_DONE, '0, 1'b0, 1'b0, '0, '0, '0));
        do_req("zero_wait", 1'b1, 1'b0, 16'h3C5F, 4);
        exp_miss = sat_inc(exp_miss);
        check("zero_wait_missCount", 64'(missCount), 64'(exp_miss));
        check("zero_wait_hitCount", 64'(hitCount), 64'(exp_hit));

        // Reset while FILL waits for memory
        preload(4'd7, 8'h00, ST_INVALID);
        ack_en = 1'b0;
        exp_q.delete();
        @(negedge clock);
        cpuRead = 1'b1; cpuAddress = 16'h7770;
        for (int i = 0; i < 10 && !memReadRequest; i++) @(negedge clock);
        check("abort_fill_seen", 64'(memReadRequest), 64'(1));
        check("abort_fill_addr", 64'(memAddress), 64'(16'h7770));
        #2 reset = 1'b0;
        #1;
        check("abort_memRd",      64'(memReadRequest), 64'(0));
        check("abort_writeTag",   64'(writeTag), 64'(0));
        check("abort_writeState", 64'(writeState), 64'(0));
        check("abort_cpuDone",    64'(cpuDone), 64'(0));
        check("abort_missCount",  64'(missCount), 64'(0));
        exp_hit = '0; exp_miss = '0;
        cpuRead = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        force_ack = 1'b1;
        @(negedge clock);
        @(negedge clock);
        force_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check("abort_no_tag_write", 64'(writeTag | writeState), 64'(0));
            check("abort_no_mem_req",   64'(memReadRequest | memWriteRequest), 64'(0));
        end
        check("abort_no_done", 64'(exp_q.size()), 64'(0));
        ack_en = 1'b1;

        // Hit counter saturation
        preload(4'd2, 8'h22, ST_VALID);
        @(negedge clock);
        force dut.r_hit_count = 16'hFFFE;
        @(negedge clock);
        release dut.r_hit_count;
        exp_hit = 16'hFFFE;
        check("sat_preset", 64'(hitCount), 64'(exp_hit));
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(mk(EV_DONE, '0, 1'b0, 1'b0, '0, '0, '0));
            do_req("sat_hit", 1'b1, 1'b0, 16'h2220, 2);
            exp_hit = sat_inc(exp_hit);
            check("sat_hitCount", 64'(hitCount), 64'(exp_hit));
        end
        check("sat_missCount", 64'(missCount), 64'(exp_miss));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cache_tag_controller.md
# cache_tag_controller

Master-side controller for the cache tag memory. It accepts single CPU read/write requests and drives the tag unit's lookup and write ports. On a miss it sequences the memory handshake: a writeback of a dirty victim, then a line fill. It then writes the new tag and state. It sits between the CPU request port, the tag unit, and the memory bus arbiter, and keeps saturating hit and miss counters.

## Interface
Parameters:
- TAG_WIDTH, 8, tag field width; address bits [ADDRESS_WIDTH-1 : INDEX_WIDTH+OFFSET_WIDTH]
- INDEX_WIDTH, 4, line index width; address bits [INDEX_WIDTH+OFFSET_WIDTH-1 : OFFSET_WIDTH]
- OFFSET_WIDTH, 4, byte offset width; ignored by this block
- ADDRESS_WIDTH, TAG_WIDTH+INDEX_WIDTH+OFFSET_WIDTH, full address width
- Fixed state encoding: INVALID=2'b00, VALID=2'b01, DIRTY=2'b10

Ports (one clock; reset is asynchronous and active-low):
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous active-low reset
- cpuRead  input  1  read request; held until cpuDone
- cpuWrite  input  1  write request; held until cpuDone; wins if asserted together with cpuRead
- cpuAddress  input  ADDRESS_WIDTH  request address; sampled in IDLE
- cpuDone  output  1  one-cycle completion pulse
- index  output  INDEX_WIDTH  tag unit index
- tagIn  output  TAG_WIDTH  tag unit compare/write tag
- stateIn  output  2  tag unit write state
- writeTag  output  1  tag unit tag write strobe
- writeState  output  1  tag unit state write strobe
- tagOut  input  TAG_WIDTH  stored tag at index (combinational)
- stateOut  input  2  stored state at index (combinational)
- hit  input  1  tag match and state != INVALID (combinational)
- memReadRequest  output  1  line fill request
- memWriteRequest  output  1  line writeback request
- memAddress  output  ADDRESS_WIDTH  line address; offset bits always zero
- memAck  input  1  memory completion, one cycle
- hitCount  output  16  saturating hit counter
- missCount  output  16  saturating miss counter

## Operation
- FSM states: IDLE, LOOKUP, WRITEBACK, FILL, UPDATE, DONE.
- IDLE
  - If cpuRead or cpuWrite is asserted: latch cpuAddress into addrReg and write = cpuWrite, then go to LOOKUP.
- index and tagIn are driven from addrReg in every state.
- LOOKUP, hit = 1
  - hitCount increments.
  - On a write: writeState = 1 and stateIn = DIRTY in this cycle.
  - Go to DONE.
- LOOKUP, hit = 0
  - missCount increments.
  - If stateOut == DIRTY: latch victim address {tagOut, index, 0} and go to WRITEBACK.
  - Otherwise go to FILL.
- WRITEBACK
  - memWriteRequest = 1 and memAddress = victim address, held until the cycle memAck = 1.
  - On memAck go to FILL.
- FILL
  - memReadRequest = 1 and memAddress = {addrReg tag, index, 0}, held until memAck = 1.
  - On memAck go to UPDATE.
- UPDATE
  - writeTag = 1 and writeState = 1.
  - stateIn = DIRTY for a write, VALID for a read.
  - Go to DONE.
- DONE
  - cpuDone = 1 for this cycle only; requests are ignored.
  - Go to IDLE.
- Memory requests are never asserted together. memAck outside WRITEBACK and FILL is ignored.
- Counters stop at 16'hFFFF and do not wrap.
- Reset values: FSM = IDLE, all strobes and requests = 0, cpuDone = 0, counters = 0, addrReg = 0.
- Reset mid-operation aborts immediately; no tag or state write is issued.

## Timing
- Request sampled at edge N; LOOKUP is cycle N+1.
- Hit: cpuDone is high in cycle N+2. A write hit's state write commits at edge N+2.
- Clean miss: FILL starts at N+2. With memAck in cycle F, UPDATE is F+1, cpuDone is F+2, and the tag/state write commits at edge F+2.
- Dirty miss: WRITEBACK starts at N+2. With memAck in cycle W, FILL starts at W+1.
- memAck in the first request cycle is legal (zero wait).
- The CPU drops its request in the cycle after cpuDone. A request still held in IDLE is treated as a new request.
- The tag unit is read combinationally: hit, tagOut and stateOut are valid in the same cycle as index.

## Test plan
- Read hit: preload index 3 with tag 8'hA5 VALID; cpuRead @16'hA530 -> cpuDone 2 cycles later, no mem requests, hitCount = 1.
- Clean read miss: index 3 INVALID; cpuRead @16'hA530; memAck 4 cycles later -> memReadRequest with memAddress 16'hA530, then writeTag/writeState with tagIn A5 and stateIn VALID, cpuDone, missCount = 1.
- Dirty write miss: index 3 holds 8'h11 DIRTY; cpuWrite @16'hA534 -> memWriteRequest @16'h1130 until ack, then memReadRequest @16'hA530, then stateIn DIRTY.
- Write hit on VALID line -> writeState with stateIn DIRTY, no writeTag, done in 2 cycles. cpuRead and cpuWrite together -> handled as write.
- Reset asserted during FILL -> outputs 0 immediately; after release, a memAck is ignored and no tag write occurs.
- Force hitCount to 16'hFFFE; three hits -> hitCount holds at 16'hFFFF.
